slcg_hyst_ctrl: RTL and testbench
=================================

SLCG_HYST_CTRL -- requirements
Module: slcg_hyst_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently gated clock channels (1..32).
REQ-002 SHALL have parameter HYST_W, default 8: width of the idle-hysteresis count.
REQ-003 SHALL have parameter CNT_W, default 16: width of the all-gated cycle counter.
REQ-004 SHALL have port nvdla_core_clk  input  1  the single free-running source clock.
REQ-005 SHALL have port nvdla_core_rst  input  1  reset, synchronous to nvdla_core_clk, active-high.
REQ-006 SHALL have port busy  input  NUM_CH  per-channel activity; upstream asserts it one cycle before the clock is needed.
REQ-007 SHALL have port gate_allow  input  NUM_CH  per-channel software permission to gate.
REQ-008 SHALL have port test_en  input  1  scan/test override that forces every channel's clock on.
REQ-009 SHALL have port hyst_cfg  input  HYST_W  idle cycles tolerated before gating.
REQ-010 SHALL have port cnt_clr  input  1  clears the all-gated counter.
REQ-011 SHALL have port clk_out  output  NUM_CH  gated clocks.
REQ-012 SHALL have port clk_active  output  NUM_CH  registered per-channel enable, en_r.
REQ-013 SHALL have port all_gated  output  1  high when every channel is in OFF.
REQ-014 SHALL have port gated_cnt  output  CNT_W  saturating count of all_gated cycles.

Function
REQ-015 Each channel SHALL run an independent FSM with states ON, HOLD and OFF, plus a HYST_W-bit down-counter, cnt.
REQ-016 ON: if gate_allow=1 and busy=0, the FSM SHALL go to HOLD and load cnt with hyst_cfg; otherwise it SHALL stay in ON.
REQ-017 HOLD: the FSM SHALL apply the first matching rule: busy=1 or gate_allow=0 -> ON; cnt==0 -> OFF; else cnt decrements by 1.
REQ-018 OFF: if busy=1 or gate_allow=0, the FSM SHALL go to ON; otherwise it SHALL stay in OFF.
REQ-019 With hyst_cfg=N and busy low from cycle k, the FSM SHALL be in HOLD during cycles k+1..k+N+1 and in OFF from k+N+2.
REQ-020 en_r SHALL be registered: 1 in ON and HOLD, 0 in OFF, updated on the same edge as the state.
REQ-021 The gate enable SHALL be en_r | test_en.
REQ-022 The gate enable SHALL be captured while nvdla_core_clk is low.
REQ-023 clk_out SHALL equal nvdla_core_clk AND the captured enable, so it carries no glitches or truncated high phases.
REQ-024 Wake latency SHALL be as follows: busy rising in OFF at edge k sets en_r at edge k+1; the first clk_out pulse is the high phase after edge k+1.
REQ-025 hyst_cfg SHALL be sampled only on the ON->HOLD transition; changes during HOLD SHALL take effect on the next entry.
REQ-026 test_en SHALL NOT alter FSM state or en_r; it SHALL affect only the gate enable.
REQ-027 all_gated SHALL be the registered AND of all channels being in OFF.
REQ-028 gated_cnt SHALL increment on each cycle all_gated=1 and SHALL saturate at 2^CNT_W-1.
REQ-029 cnt_clr SHALL zero gated_cnt next cycle, taking priority over a simultaneous increment.
REQ-030 busy and gate_allow edges arriving on the same cycle SHALL be resolved by the priority order in REQ-017 and REQ-018.

Reset
REQ-031 While nvdla_core_rst is sampled high, every channel SHALL go to ON with cnt=0, en_r=1, clk_active all ones, all_gated=0 and gated_cnt=0.
REQ-032 A reset asserted mid-HOLD or mid-OFF SHALL return the channel to ON at the next rising edge, so downstream logic receives clocks during reset.
REQ-033 Before the first reset edge, clk_out SHALL be don't-care; the bench SHALL hold reset for at least 2 cycles.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (ON=2'd0, HOLD=2'd1, OFF=2'd2) and the default parameter constants.
REQ-035 A sub-module, slcg_gate_cell, SHALL contain the low-phase enable capture and the AND, instantiated NUM_CH times.
REQ-036 The FSM and counters SHALL be a generate loop in the top module.
REQ-037 The block SHALL contain no other clock-domain logic.

Verification
REQ-038 Reset then idle, with hyst_cfg=3, gate_allow=all ones, busy=0: OFF is entered at cycle 5 after reset release, and clk_out stops from cycle 6.
REQ-039 HOLD abort, with hyst_cfg=5 and busy pulsed at the 3rd HOLD cycle: the channel returns to ON, clk_out never stops, and cnt reloads 5 on the next entry.
REQ-040 Wake from OFF, busy rising at edge 20: en_r=1 at edge 21 and a full-width clk_out pulse follows edge 21, with no runt pulse.
REQ-041 test_en=1 while all channels are OFF: all clk_out toggle every cycle while clk_active stays 0 and all_gated stays 1.
REQ-042 Counter check, with CNT_W=4 and all channels OFF for 20 cycles: gated_cnt saturates at 15, and cnt_clr together with all_gated gives 0 next cycle.
REQ-043 Reset mid-OFF on channel 2 with NUM_CH=4: all channels are ON and clk_active=4'b1111 one edge after reset is sampled.

Source files
------------

// File: rtl/slcg_hyst_ctrl_pkg.sv
// Shared types and default sizing for the hysteretic clock-gating controller.
package slcg_hyst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_HOLD = 2'd1,
    ST_OFF  = 2'd2
  } slcg_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_HYST_W = 8;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/slcg_gate_cell.sv
// Glitch-free clock gate: enable is captured while clk is low, then ANDed with clk.
module slcg_gate_cell (
  input  logic clk,
  input  logic en,
  output logic clk_out
);

  logic en_lat;

  // Transparent only during the low phase, so the enable can never change
  // while clk is high and a high phase is always passed whole or not at all.
  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign clk_out = clk & en_lat;

endmodule

// File: rtl/slcg_hyst_ctrl.sv
// Per-channel clock gating with idle hysteresis plus an all-gated cycle counter.
//   state   | meaning
//   ST_ON   | clock running, channel busy or gating not allowed
//   ST_HOLD | idle, counting down hyst_cfg cycles before gating
//   ST_OFF  | clock gated
module slcg_hyst_ctrl
  import slcg_hyst_ctrl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int HYST_W = DEF_HYST_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic [NUM_CH-1:0] busy,
  input  logic [NUM_CH-1:0] gate_allow,
  input  logic              test_en,
  input  logic [HYST_W-1:0] hyst_cfg,
  input  logic              cnt_clr,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_active,
  output logic              all_gated,
  output logic [CNT_W-1:0]  gated_cnt
);

  logic [NUM_CH-1:0] ch_off;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    slcg_state_e       state;
    logic [HYST_W-1:0] cnt;
    logic              en_r;

    always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
        state <= ST_ON;
        cnt   <= '0;
        en_r  <= 1'b1;
      end else begin
        case (state)
          ST_ON: begin
            if (gate_allow[g] && !busy[g]) begin
              state <= ST_HOLD;
              cnt   <= hyst_cfg;
            end
          end
          ST_HOLD: begin
            if (busy[g] || !gate_allow[g]) begin
              state <= ST_ON;
              en_r  <= 1'b1;
            end else if (cnt == '0) begin
              state <= ST_OFF;
              en_r  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_OFF: begin
            if (busy[g] || !gate_allow[g]) begin
              state <= ST_ON;
              en_r  <= 1'b1;
            end
          end
          default: begin
            state <= ST_ON;
            en_r  <= 1'b1;
          end
        endcase
      end
    end

    assign ch_off[g]     = (state == ST_OFF);
    assign clk_active[g] = en_r;

    // test_en only overrides the gate itself; FSM state and en_r are untouched.
    slcg_gate_cell u_gate (
      .clk     (nvdla_core_clk),
      .en      (en_r | test_en),
      .clk_out (clk_out[g])
    );
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      all_gated <= 1'b0;
      gated_cnt <= '0;
    end else begin
      all_gated <= &ch_off;
      if (cnt_clr)
        gated_cnt <= '0;
      else if (all_gated && (gated_cnt != '1))
        gated_cnt <= gated_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_slcg_hyst_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic vs a run-length model.
module tb_slcg_hyst_ctrl;

  localparam int NCH = 4;
  localparam int HW  = 8;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] busy = '0;
  logic [NCH-1:0] allow = '1;
  logic           te = 1'b0;
  logic [HW-1:0]  hyst = 8'd3;
  logic           clr = 1'b0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] clk_active;
  logic           all_gated;
  logic [CW-1:0]  gated_cnt;

  int total = 0;
  int bad   = 0;

  slcg_hyst_ctrl #(.NUM_CH(NCH), .HYST_W(HW), .CNT_W(CW)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .busy           (busy),
    .gate_allow     (allow),
    .test_en        (te),
    .hyst_cfg       (hyst),
    .cnt_clr        (clr),
    .clk_out        (clk_out),
    .clk_active     (clk_active),
    .all_gated      (all_gated),
    .gated_cnt      (gated_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a channel's state is a function of how many consecutive edges it has
  // sampled idle (busy=0, allow=1) and the hyst value seen on the first of them.
  int             idle [NCH];
  int             hy   [NCH];
  logic [NCH-1:0] m_en;
  logic           m_ag;
  int             m_gc;
  bit             mv = 0;

  always @(posedge clk) begin
    logic [NCH-1:0] exp_clk;
    logic [NCH-1:0] off_now;
    bit             chk_clk;
    chk_clk = mv;
    exp_clk = m_en | {NCH{te}};
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin idle[i] = 0; hy[i] = 0; end
      m_en = '1; m_ag = 1'b0; m_gc = 0; mv = 1;
    end else if (mv) begin
      off_now = ~m_en;
      if (clr) m_gc = 0;
      else if (m_ag && m_gc < SAT) m_gc++;
      m_ag = &off_now;
      for (int i = 0; i < NCH; i++) begin
        if (!busy[i] && allow[i]) begin
          if (idle[i] == 0) hy[i] = int'(hyst);
          if (idle[i] < 100000) idle[i]++;
        end else begin
          idle[i] = 0;
        end
        m_en[i] = !(idle[i] > 0 && idle[i] >= hy[i] + 2);
      end
    end
    #2;
    if (chk_clk) check("clk_out", clk_out, exp_clk);
    if (mv) begin
      check("clk_active", clk_active, m_en);
      check("all_gated", all_gated, m_ag);
      check("gated_cnt", gated_cnt, m_gc);
    end
  end

  initial begin
    int n;
    // Reset held for 3 edges.
    repeat (3) @(negedge clk);
    check("rst_active", clk_active, 4'hF);
    check("rst_all_gated", all_gated, 1'b0);
    check("rst_gated_cnt", gated_cnt, 0);

    // Idle after release with hyst=3: OFF after edge 5, clk_out stops at edge 6.
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_edge4_active", clk_active, 4'hF);
    @(negedge clk);
    check("idle_edge5_active", clk_active, 4'h0);
    @(posedge clk); #2;
    check("idle_edge6_clk_out", clk_out, 4'h0);
    @(negedge clk);

    // Counter saturation.
    repeat (20) @(negedge clk);
    check("sat_gated_cnt", gated_cnt, 15);
    check("sat_all_gated", all_gated, 1'b1);

    // test_en forces clocks without touching FSM state.
    te = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("te_clk_high", clk_out, 4'hF);
      @(negedge clk);
      check("te_clk_low", clk_out, 4'h0);
      check("te_active", clk_active, 4'h0);
      check("te_all_gated", all_gated, 1'b1);
    end
    te = 1'b0;
    @(negedge clk);

    // cnt_clr beats a simultaneous increment.
    clr = 1'b1;
    @(negedge clk);
    check("clr_gated_cnt", gated_cnt, 0);
    clr = 1'b0;
    @(negedge clk);
    check("clr_restart", gated_cnt, 1);

    // Wake channel 1 from OFF.
    busy[1] = 1'b1;
    @(posedge clk); #2;
    check("wake_no_runt", clk_out[1], 1'b0);
    @(negedge clk);
    check("wake_active", clk_active, 4'b0010);
    @(posedge clk); #1;
    check("wake_pulse_early", clk_out[1], 1'b1);
    #3;
    check("wake_pulse_late", clk_out[1], 1'b1);
    @(negedge clk);
    busy[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("regate_active", clk_active, 4'h0);

    // Reset while everything is OFF.
    rst = 1'b1;
    @(negedge clk);
    check("rst_midoff_active", clk_active, 4'hF);

    // HOLD abort on channel 0 with hyst=5, then hyst change during the next HOLD.
    hyst = 8'd5;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    busy[0] = 1'b1;
    @(negedge clk);
    busy[0] = 1'b0;
    check("abort_active", clk_active[0], 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) hyst = 8'd1;
    end while (clk_active[0] && n < 20);
    check("abort_reentry_len", n, 7);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        busy[i]  = ($urandom_range(0, 9) < 2);
        allow[i] = ($urandom_range(0, 19) != 0);
      end
      if ($urandom_range(0, 3) == 0) busy = '0;
      te   = ($urandom_range(0, 29) == 0);
      clr  = ($urandom_range(0, 39) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) hyst = 8'($urandom_range(0, 6));
    end
    @(negedge clk);
    rst = 1'b0; busy = '0; allow = '1; te = 1'b0; clr = 1'b0;
    repeat (30) @(negedge clk);
    check("final_all_gated", all_gated, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
